// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// default word format and the wait-counter width helper.
package instr_fetch_seq_pkg;

    localparam int          DEF_DATA_W    = 16;
    localparam logic [15:0] DEF_HALT_WORD = 16'hFFFF;

    // Encoding is exported on State for the debug LEDs, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LATCH     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_EXEC      = 3'd4,
        ST_STEP_WAIT = 3'd5,
        ST_HALTED    = 3'd6
    } fetch_state_t;

    // One counter serves both the memory latency and the Done timeout,
    // so it must be wide enough for whichever value is larger.
    function automatic int ctr_width(input int max_wait, input int mem_lat);
        int w;
        w = $clog2(max_wait + 1);
        if ($clog2(mem_lat) > w) w = $clog2(mem_lat);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/instr_fetch_seq_wait_ctr.sv
// fetch_wait_ctr: loadable up/down counter. Counts down while waiting out
// the memory read latency and up while timing the proc's Done response.
module instr_fetch_seq_wait_ctr #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic         count_down,
    output logic [W-1:0] count
);

    // Load has priority over counting; the counter holds when not enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count_down ? count - W'(1) : count + W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: reads words from a synchronous instruction
// memory, presents each on DIN, pulses Run and waits for Done from proc.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | after reset; Load_PC allowed, Go starts fetching
//   FETCH      | mem_addr = PC, waiting MEM_LAT clocks for mem_q
//   LATCH      | capture mem_q; halt word stops here without issuing
//   ISSUE      | Run pulse, Issued increments
//   EXEC       | waiting for Done, timing out after MAX_WAIT clocks
//   STEP_WAIT  | single-step pause until a fresh rising Go
//   HALTED     | stopped; Load_PC allowed, Go restarts unless timed out
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
#(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                MEM_LAT   = 1,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEF_HALT_WORD),
    parameter int                MAX_WAIT  = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Go,
    input  logic              Step,
    input  logic              Stop,
    input  logic              Load_PC,
    input  logic [ADDR_W-1:0] PC_In,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Timeout,
    output logic [ADDR_W-1:0] PC,
    output logic [7:0]        Issued,
    output logic [2:0]        State
);

    localparam int               CTR_W      = ctr_width(MAX_WAIT, MEM_LAT);
    localparam logic [CTR_W-1:0] FETCH_LOAD = CTR_W'(MEM_LAT - 1);
    // Done is still accepted in the cycle the counter sits here; one more
    // cycle without it would exceed MAX_WAIT clocks after Run.
    localparam logic [CTR_W-1:0] WAIT_LAST  = CTR_W'(MAX_WAIT - 1);

    fetch_state_t     state, state_next;
    logic [CTR_W-1:0] wait_count;
    logic [CTR_W-1:0] ctr_value;
    logic             ctr_load, ctr_enable, ctr_down;
    logic             pc_load, pc_inc, din_load, issued_inc, timeout_set;
    logic             go_armed, go_armed_clr;

    instr_fetch_seq_wait_ctr #(.W(CTR_W)) u_wait_ctr (
        .clock      (Clock),
        .reset      (Reset),
        .load       (ctr_load),
        .load_value (ctr_value),
        .enable     (ctr_enable),
        .count_down (ctr_down),
        .count      (wait_count)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next   = state;
        ctr_load     = 1'b0;
        ctr_value    = FETCH_LOAD;
        ctr_enable   = 1'b0;
        ctr_down     = 1'b1;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        din_load     = 1'b0;
        issued_inc   = 1'b0;
        timeout_set  = 1'b0;
        go_armed_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Load_PC) begin
                    pc_load = 1'b1;
                end else if (Go) begin
                    state_next = ST_FETCH;
                    ctr_load   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (wait_count == '0) state_next = ST_LATCH;
                else                  ctr_enable = 1'b1;
            end
            ST_LATCH: begin
                if (mem_q == HALT_WORD) begin
                    state_next = ST_HALTED;
                end else begin
                    din_load   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issued_inc = 1'b1;
                ctr_load   = 1'b1;
                ctr_value  = '0;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                ctr_enable = 1'b1;
                ctr_down   = 1'b0;
                if (Done) begin
                    pc_inc = 1'b1;
                    if (Stop) begin
                        state_next = ST_HALTED;
                    end else if (Step) begin
                        state_next   = ST_STEP_WAIT;
                        go_armed_clr = 1'b1;
                    end else begin
                        state_next = ST_FETCH;
                        ctr_load   = 1'b1;
                    end
                end else if (wait_count == WAIT_LAST) begin
                    timeout_set = 1'b1;
                    state_next  = ST_HALTED;
                end
            end
            ST_STEP_WAIT: begin
                if (Stop) begin
                    state_next = ST_HALTED;
                end else if (Go && go_armed) begin
                    state_next = ST_FETCH;
                    ctr_load   = 1'b1;
                end
            end
            ST_HALTED: begin
                if (Load_PC) begin
                    pc_load = 1'b1;
                end else if (Go && !Timeout) begin
                    state_next = ST_FETCH;
                    ctr_load   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // PC, instruction word, issue count, sticky timeout and step-mode Go edge tracking.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            PC       <= '0;
            DIN      <= '0;
            Issued   <= '0;
            Timeout  <= 1'b0;
            go_armed <= 1'b0;
        end else begin
            if (pc_load)          PC <= PC_In;
            else if (pc_inc)      PC <= PC + ADDR_W'(1);
            if (din_load)         DIN <= mem_q;
            if (issued_inc)       Issued <= Issued + 8'd1;
            if (timeout_set)      Timeout <= 1'b1;
            // Go must be seen low while paused before a high Go counts as a new step.
            if (go_armed_clr)                        go_armed <= 1'b0;
            else if (state == ST_STEP_WAIT && !Go)   go_armed <= 1'b1;
        end
    end

    assign mem_addr = PC;
    assign Run      = (state == ST_ISSUE);
    assign Halted   = (state == ST_HALTED);
    assign Busy     = !(state == ST_IDLE || state == ST_HALTED || state == ST_STEP_WAIT);
    assign State    = state;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: behavioural memory, a Done responder, and a
// program-level reference model that predicts issued words, final PC,
// issue count and timeout from the memory image and Done delays.
module tb_instr_fetch_seq;

    localparam int          MEM_LAT  = 2;
    localparam int          MAX_WAIT = 8;
    localparam logic [15:0] HALT     = 16'hFFFF;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Go = 1'b0, Step = 1'b0, Stop = 1'b0, Load_PC = 1'b0, Done = 1'b0;
    logic [4:0]  PC_In = '0;
    logic [4:0]  mem_addr, PC;
    logic [15:0] mem_q, DIN;
    logic        Run, Busy, Halted, Timeout;
    logic [7:0]  Issued;
    logic [2:0]  State;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [32];
    logic [15:0] pipe1 = '0, pipe2 = '0;

    int          delay_q[$];
    logic [15:0] seen_din[$];
    int          run_count = 0;
    int          stop_pc = -1;
    logic        stop_level = 1'b0;

    logic [15:0] exp_din[$];
    int          exp_pc;
    bit          exp_to;
    int          exp_issued = 0;

    instr_fetch_seq #(
        .ADDR_W(5), .DATA_W(16), .MEM_LAT(MEM_LAT), .HALT_WORD(HALT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Go(Go), .Step(Step), .Stop(Stop),
        .Load_PC(Load_PC), .PC_In(PC_In), .mem_addr(mem_addr), .mem_q(mem_q),
        .DIN(DIN), .Run(Run), .Done(Done), .Busy(Busy), .Halted(Halted),
        .Timeout(Timeout), .PC(PC), .Issued(Issued), .State(State)
    );

    always #5 Clock = ~Clock;

    // Synchronous-read memory with MEM_LAT = 2 clocks of latency.
    always @(posedge Clock) begin
        pipe1 <= mem[mem_addr];
        pipe2 <= pipe1;
    end
    assign mem_q = pipe2;

    // Proc stand-in: records DIN at each Run, answers with Done after the
    // next queued delay (0 = never), optionally with Stop at stop_pc.
    initial begin : responder
        int   cd;
        int   d;
        logic sp;
        cd = -1;
        forever begin
            @(negedge Clock);
            Done = 1'b0;
            sp   = 1'b0;
            if (Reset) begin
                cd = -1;
            end else if (Run === 1'b1) begin
                run_count++;
                seen_din.push_back(DIN);
                d  = (delay_q.size() > 0) ? delay_q.pop_front() : 3;
                cd = (d == 0) ? -1 : d;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    Done = 1'b1;
                    sp   = (stop_pc >= 0) && (int'(PC) == stop_pc);
                    cd   = -1;
                end
            end
            Stop = stop_level | sp;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},      PC, 0);
        chk({tag, "_addr"},    mem_addr, 0);
        chk({tag, "_din"},     DIN, 0);
        chk({tag, "_run"},     Run, 0);
        chk({tag, "_busy"},    Busy, 0);
        chk({tag, "_halted"},  Halted, 0);
        chk({tag, "_timeout"}, Timeout, 0);
        chk({tag, "_issued"},  Issued, 0);
        chk({tag, "_state"},   State, 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1; Go = 1'b0; Load_PC = 1'b0;
        tick(2);
        Reset = 1'b0;
        exp_issued = 0;
    endtask

    task automatic load_pc(input int v);
        Load_PC = 1'b1;
        PC_In   = 5'(v);
        tick(1);
        Load_PC = 1'b0;
        chk("load_pc", PC, v);
    endtask

    task automatic fill_random_mem();
        logic [15:0] w;
        for (int i = 0; i < 32; i++) begin
            w = 16'($urandom);
            if (w == HALT) w = 16'h1234;
            mem[i] = w;
        end
    endtask

    // Program-level prediction: walk memory from start, one instruction per
    // queued Done delay, until a halt word, a timeout or a Stop with Done.
    task automatic model(input int start);
        int pc, k, d;
        pc = start; k = 0;
        exp_din.delete();
        exp_to = 1'b0;
        for (int g = 0; g < 64; g++) begin
            if (mem[pc] == HALT) break;
            exp_din.push_back(mem[pc]);
            d = (k < delay_q.size()) ? delay_q[k] : 3;
            k++;
            if (d == 0 || d > MAX_WAIT) begin
                exp_to = 1'b1;
                break;
            end
            if (pc == stop_pc) begin
                pc = (pc + 1) % 32;
                break;
            end
            pc = (pc + 1) % 32;
        end
        exp_pc = pc;
    endtask

    task automatic run_prog(input string tag, input int start);
        int n, run_at, r0;
        model(start);
        r0 = run_count;
        seen_din.delete();
        Go = 1'b1;
        tick(1);
        Go = 1'b0;
        n = 1;
        while (Run !== 1'b1 && Halted !== 1'b1 && n < 50) begin
            tick(1); n++;
        end
        if (exp_din.size() > 0) chk({tag, "_go_to_run"}, n, MEM_LAT + 2);
        run_at = n;
        while (Halted !== 1'b1 && n < 3000) begin
            if (Run === 1'b1) run_at = n;
            tick(1); n++;
        end
        chk({tag, "_halted"}, Halted, 1);
        if (exp_to) chk({tag, "_timeout_latency"}, n - run_at, MAX_WAIT + 1);
        tick(6);
        exp_issued = (exp_issued + exp_din.size()) % 256;
        chk({tag, "_run_count"}, run_count - r0, exp_din.size());
        for (int i = 0; i < exp_din.size(); i++)
            chk({tag, "_din"}, (i < seen_din.size()) ? seen_din[i] : 16'hxxxx, exp_din[i]);
        chk({tag, "_pc"},      PC, exp_pc);
        chk({tag, "_issued"},  Issued, exp_issued);
        chk({tag, "_timeout"}, Timeout, exp_to);
        chk({tag, "_still_halted"}, Halted, 1);
        chk({tag, "_busy"},    Busy, 0);
        chk({tag, "_state"},   State, 6);
    endtask

    initial begin : main
        int r0, n, hp, st, r;

        // Reset state
        fill_random_mem();
        Reset = 1'b1;
        tick(3);
        chk_reset_vals("reset");
        Reset = 1'b0;

        // Two instructions then a halt word
        mem[0] = 16'hA001; mem[1] = 16'hB002; mem[2] = HALT;
        delay_q = {3, 3};
        run_prog("t1", 0);

        // Load_PC and Go together in IDLE: load wins, Go dropped; then wrap at 31
        do_reset();
        mem[31] = 16'h7E31; mem[0] = HALT;
        Load_PC = 1'b1; PC_In = 5'd31; Go = 1'b1;
        tick(1);
        Load_PC = 1'b0; Go = 1'b0;
        tick(4);
        chk("t4_load_pc", PC, 31);
        chk("t4_go_dropped_state", State, 0);
        chk("t4_go_dropped_busy", Busy, 0);
        delay_q = {2};
        run_prog("t4", 31);

        // Single step: one Run per Go rising edge, Go held high does not repeat
        fill_random_mem();
        mem[13] = HALT;
        load_pc(10);
        Step = 1'b1;
        delay_q = {2, 2, 2};
        for (int k = 0; k < 3; k++) begin
            r0 = run_count;
            Go = 1'b1;
            tick(k == 0 ? 12 : 1);
            Go = 1'b0;
            tick(12);
            chk("t2_one_run", run_count - r0, 1);
            chk("t2_state", State, 5);
            chk("t2_din", DIN, mem[10 + k]);
            chk("t2_pc", PC, 11 + k);
            chk("t2_busy", Busy, 0);
        end
        stop_level = 1'b1;
        tick(3);
        stop_level = 1'b0;
        Step = 1'b0;
        exp_issued = (exp_issued + 3) % 256;
        chk("t2_stop_halted", Halted, 1);
        chk("t2_issued", Issued, exp_issued);

        // Stop together with Done at PC=4
        fill_random_mem();
        mem[9] = HALT;
        load_pc(2);
        stop_pc = 4;
        delay_q = {$urandom_range(1, MAX_WAIT), $urandom_range(1, MAX_WAIT), $urandom_range(1, MAX_WAIT)};
        run_prog("t5", 2);
        stop_pc = -1;

        // Done in the last allowed cycle wins over timeout
        mem[20] = 16'h2020; mem[21] = 16'h2121; mem[22] = HALT;
        load_pc(20);
        delay_q = {MAX_WAIT, 1};
        run_prog("done_at_max", 20);

        // Done never arrives: timeout, PC held, Go ignored afterwards
        load_pc(20);
        delay_q = {0};
        run_prog("t3", 20);
        r0 = run_count;
        Go = 1'b1;
        tick(2);
        Go = 1'b0;
        tick(8);
        chk("t3_go_ignored_runs", run_count - r0, 0);
        chk("t3_go_ignored_halted", Halted, 1);
        chk("t3_timeout_sticky", Timeout, 1);
        chk("t3_pc_held", PC, 20);

        // Reset during EXEC, then rerun the first program
        do_reset();
        mem[0] = 16'hA001; mem[1] = 16'hB002; mem[2] = HALT;
        delay_q = {0};
        Go = 1'b1;
        tick(1);
        Go = 1'b0;
        n = 1;
        while (Run !== 1'b1 && n < 50) begin
            tick(1); n++;
        end
        chk("t6_run_seen", Run, 1);
        tick(1);
        chk("t6_in_exec", State, 4);
        Reset = 1'b1;
        tick(1);
        chk_reset_vals("t6_reset");
        Reset = 1'b0;
        delay_q.delete();
        delay_q = {3, 3};
        exp_issued = 0;
        run_prog("t6_rerun", 0);

        // Randomised programs
        for (int it = 0; it < 6; it++) begin
            fill_random_mem();
            hp = $urandom_range(0, 31);
            mem[hp] = HALT;
            st = $urandom_range(0, 31);
            load_pc(st);
            stop_pc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
            delay_q.delete();
            for (int j = 0; j < 40; j++) begin
                r = $urandom_range(0, 15);
                if (r == 0)      delay_q.push_back(0);
                else if (r == 1) delay_q.push_back(MAX_WAIT + 1);
                else if (r < 5)  delay_q.push_back(MAX_WAIT);
                else             delay_q.push_back($urandom_range(1, MAX_WAIT));
            end
            run_prog("rand", st);
            stop_pc = -1;
            if (exp_to) do_reset();
        end

        // Long runs through the whole memory to wrap Issued past 255
        do_reset();
        fill_random_mem();
        mem[0] = HALT;
        for (int it = 0; it < 9; it++) begin
            load_pc(1);
            delay_q.delete();
            run_prog("wrap", 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
